// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and constants for the data-bus arbiter
package dbus_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    PER_WAIT = 1'b1
  } state_t;

  typedef logic master_id_t;

  localparam master_id_t M0_ID = 1'b0;
  localparam master_id_t M1_ID = 1'b1;

  localparam int MODE_BYTE = 3;
  localparam int MODE_HALF = 2;
  localparam int MODE_WORD = 1;
  localparam int MODE_UNS  = 0;

  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  function automatic logic addr_is_per(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/dbus_if.sv
// rtl/dbus_if.sv - one master's request/response port onto the data bus
interface dbus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mode;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, wdata, mode, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, mode, output gnt, rdata, rvalid);
endinterface

// File: rtl/dbus_rd_tracker.sv
// rtl/dbus_rd_tracker.sv - fixed-latency shift register of outstanding RAM reads
module dbus_rd_tracker
  import dbus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rstB_i,
  input  logic       push_i,
  input  master_id_t push_id_i,
  output logic       pop_valid_o,
  output master_id_t pop_id_o,
  output logic       empty_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] id_q;

  always_ff @(posedge clk_i or negedge rstB_i) begin
    if (!rstB_i) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= push_i;
      id_q[0]    <= push_id_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign pop_valid_o = valid_q[DEPTH-1];
  assign pop_id_o    = master_id_t'(id_q[DEPTH-1]);

  // The entry returning this cycle does not count: nothing is outstanding after it.
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (valid_q[i]) empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master data-bus arbiter with RAM/peripheral decode; optional DBUS_TIMEOUT_EN
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int          RAM_RD_LAT = 2,
  parameter logic [31:0] PER_BASE   = 32'h1000_0000,
  parameter logic [31:0] PER_MASK   = 32'hF000_0000,
  parameter int          STARVE_LIM = 4
`ifdef DBUS_TIMEOUT_EN
  , parameter int        TMO_CYC    = 255
`endif
) (
  input  logic        clk_i,
  input  logic        rstB_i,
  dbus_if.slave       m0,
  dbus_if.slave       m1,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_mode_o,
  input  logic [31:0] ram_rdata_i,
  output logic        per_sel_o,
  output logic        per_we_o,
  output logic [31:0] per_addr_o,
  output logic [31:0] per_wdata_o,
  input  logic [31:0] per_rdata_i,
  input  logic        per_rvalid_i,
`ifdef DBUS_TIMEOUT_EN
  output logic [7:0]  tmo_cnt_o,
`endif
  output logic        busy_o
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  state_t      state_q;
  master_id_t  lat_id_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  logic        sel_m1, cand_req, cand_we, cand_per, grant;
  logic [31:0] cand_addr, cand_wdata;
  logic [3:0]  cand_mode;
  logic        trk_push, trk_pop_valid, trk_empty;
  master_id_t  trk_pop_id;
  logic        tmo_hit, per_done, m0_ret, m1_ret;
  logic [31:0] per_data, ret_data;

  always_comb begin
    sel_m1     = m1.req & (~m0.req | (starve_q == SW'(STARVE_LIM)));
    cand_req   = sel_m1 | m0.req;
    cand_we    = sel_m1 ? m1.we    : m0.we;
    cand_addr  = sel_m1 ? m1.addr  : m0.addr;
    cand_wdata = sel_m1 ? m1.wdata : m0.wdata;
    cand_mode  = sel_m1 ? m1.mode  : m0.mode;
  end

  assign cand_per = addr_is_per(cand_addr, PER_BASE, PER_MASK);
  // A peripheral read must not overlap a RAM return, so it waits for the tracker to drain.
  assign grant    = rstB_i & (state_q == IDLE) & cand_req
                  & ~(cand_per & ~cand_we & ~trk_empty);
  assign m0.gnt   = grant & ~sel_m1;
  assign m1.gnt   = grant & sel_m1;

  assign ram_en_o    = grant & ~cand_per;
  assign ram_we_o    = ram_en_o & cand_we;
  assign ram_addr_o  = ram_en_o ? cand_addr  : '0;
  assign ram_wdata_o = ram_en_o ? cand_wdata : '0;
  assign ram_mode_o  = ram_en_o ? cand_mode  : '0;
  assign per_sel_o   = grant & cand_per;
  assign per_we_o    = per_sel_o & cand_we;
  assign per_addr_o  = per_sel_o ? cand_addr  : '0;
  assign per_wdata_o = per_sel_o ? cand_wdata : '0;

  assign trk_push = ram_en_o & ~cand_we;

  dbus_rd_tracker #(.DEPTH(RAM_RD_LAT)) u_trk (
    .clk_i       (clk_i),
    .rstB_i      (rstB_i),
    .push_i      (trk_push),
    .push_id_i   (sel_m1 ? M1_ID : M0_ID),
    .pop_valid_o (trk_pop_valid),
    .pop_id_o    (trk_pop_id),
    .empty_o     (trk_empty)
  );

  assign per_done = (state_q == PER_WAIT) & (per_rvalid_i | tmo_hit);
  assign per_data = per_rvalid_i ? per_rdata_i : TMO_DATA;
  assign ret_data = trk_pop_valid ? ram_rdata_i : per_data;
  assign m0_ret   = (trk_pop_valid & (trk_pop_id == M0_ID)) | (per_done & (lat_id_q == M0_ID));
  assign m1_ret   = (trk_pop_valid & (trk_pop_id == M1_ID)) | (per_done & (lat_id_q == M1_ID));

  assign m0.rvalid = m0_ret;
  assign m1.rvalid = m1_ret;
  assign m0.rdata  = m0_ret ? ret_data : m0_rdata_q;
  assign m1.rdata  = m1_ret ? ret_data : m1_rdata_q;

  assign busy_o = (state_q == PER_WAIT) | trk_push | ~trk_empty | trk_pop_valid;

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (m1.gnt)                                      starve_d = '0;
      else if (m1.req && starve_q != SW'(STARVE_LIM)) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstB_i) begin
    if (!rstB_i) begin
      state_q    <= IDLE;
      lat_id_q   <= M0_ID;
      starve_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (m0_ret) m0_rdata_q <= ret_data;
      if (m1_ret) m1_rdata_q <= ret_data;
      case (state_q)
        IDLE: if (per_sel_o && !cand_we) begin
          state_q  <= PER_WAIT;
          lat_id_q <= sel_m1 ? M1_ID : M0_ID;
        end
        PER_WAIT: if (per_done) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_ctr_q, tmo_cnt_q;

  assign tmo_hit   = (state_q == PER_WAIT) & (tmo_ctr_q == 8'(TMO_CYC));
  assign tmo_cnt_o = tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rstB_i) begin
    if (!rstB_i) begin
      tmo_ctr_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      tmo_ctr_q <= (state_q == PER_WAIT && !per_done) ? tmo_ctr_q + 8'd1 : 8'd0;
      if (tmo_hit && !per_rvalid_i && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - scoreboard bench for dbus_arbiter; honours DBUS_TIMEOUT_EN
module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstB = 1'b0;
  always #5 clk = ~clk;

  dbus_if m0_bus ();
  dbus_if m1_bus ();

  logic        ram_en, ram_we, per_sel, per_we, per_rvalid, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, per_addr, per_wdata, per_rdata;
  logic [3:0]  ram_mode;
`ifdef DBUS_TIMEOUT_EN
  logic [7:0]  tmo_cnt;
`endif

  dbus_arbiter #(.RAM_RD_LAT(LAT)) dut (
    .clk_i        (clk),
    .rstB_i       (rstB),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_mode_o   (ram_mode),
    .ram_rdata_i  (ram_rdata),
    .per_sel_o    (per_sel),
    .per_we_o     (per_we),
    .per_addr_o   (per_addr),
    .per_wdata_o  (per_wdata),
    .per_rdata_i  (per_rdata),
    .per_rvalid_i (per_rvalid),
`ifdef DBUS_TIMEOUT_EN
    .tmo_cnt_o    (tmo_cnt),
`endif
    .busy_o       (busy)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // RAM model: data for the address issued LAT cycles earlier
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= ram_addr;
  end
  assign ram_rdata = ram_word(rd_pipe[LAT-1]);

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (m0_bus.rvalid) begin
      if (q0.size() == 0) check("m0_spurious_rvalid", 32'(m0_bus.rvalid), 32'd0);
      else                check("m0_rdata", m0_bus.rdata, q0.pop_front());
    end
    if (m1_bus.rvalid) begin
      if (q1.size() == 0) check("m1_spurious_rvalid", 32'(m1_bus.rvalid), 32'd0);
      else                check("m1_rdata", m1_bus.rdata, q1.pop_front());
    end
  end

  task automatic drive(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_bus.req = 1'b1; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = d;
      m0_bus.mode = 4'(1 << MODE_WORD);
    end else begin
      m1_bus.req = 1'b1; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = d;
      m1_bus.mode = 4'(1 << MODE_WORD);
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) m0_bus.req = 1'b0;
    else        m1_bus.req = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  int hit;

  initial begin
    m0_bus.req = 0; m0_bus.we = 0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.mode = 0;
    m1_bus.req = 0; m1_bus.we = 0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.mode = 0;
    per_rvalid = 0; per_rdata = 0;

    // reset state, with a request pending to show grants are suppressed
    drive(0, 1'b0, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_m0_gnt", 32'(m0_bus.gnt), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m0_rdata", m0_bus.rdata, 32'd0);
    check("rst_m1_rvalid", 32'(m1_bus.rvalid), 32'd0);
    drop(0);
    rstB = 1'b1;

    // starvation: m1 wins the fifth arbitration
    for (int c = 0; c <= 6; c++) begin
      cyc();
      if (c == 0) begin drive(0, 1'b0, 32'h100, 32'h0); drive(1, 1'b0, 32'h100, 32'h0); end
      if (c == 5) begin drop(0); drop(1); end
      if (c < 4)  q0.push_back(ram_word(32'h100));
      if (c == 4) q1.push_back(ram_word(32'h100));
      @(negedge clk);
      if (c <= 4) begin
        check("t1_m0_gnt", 32'(m0_bus.gnt), 32'(c < 4));
        check("t1_m1_gnt", 32'(m1_bus.gnt), 32'(c == 4));
      end
      if (c == 6) check("t1_m1_rvalid_c6", 32'(m1_bus.rvalid), 32'd1);
    end
    repeat (3) cyc();

    // back-to-back RAM reads
    for (int c = 0; c <= 5; c++) begin
      cyc();
      if (c < 3) begin
        drive(0, 1'b0, 32'(4 * c), 32'h0);
        q0.push_back(ram_word(32'(4 * c)));
      end else drop(0);
      @(negedge clk);
      check("t2_m0_gnt", 32'(m0_bus.gnt), 32'(c < 3));
      check("t2_busy", 32'(busy), 32'(c <= 4));
      check("t2_m0_rvalid", 32'(m0_bus.rvalid), 32'(c >= 2 && c <= 4));
    end
    repeat (2) cyc();

    // peripheral read waits for the RAM read to drain
    for (int c = 0; c <= 8; c++) begin
      cyc();
      per_rvalid = 1'b0;
      if (c == 0) begin drive(0, 1'b0, 32'h0, 32'h0); q0.push_back(ram_word(32'h0)); end
      if (c == 1) drive(0, 1'b0, 32'h1000_0000, 32'h0);
      if (c == 3) drop(0);
      if (c == 5) begin per_rvalid = 1'b1; per_rdata = 32'h41; q0.push_back(32'h41); end
      if (c == 7) begin per_rvalid = 1'b1; per_rdata = 32'h99; end
      @(negedge clk);
      if (c <= 2) check("t3_m0_gnt", 32'(m0_bus.gnt), 32'(c != 1));
      if (c >= 1 && c <= 4) check("t3_per_sel", 32'(per_sel), 32'(c == 2));
      if (c == 2) check("t3_ram_rvalid_c2", 32'(m0_bus.rvalid), 32'd1);
      if (c == 4) check("t3_busy_wait", 32'(busy), 32'd1);
      if (c == 5) check("t3_per_rvalid_c5", 32'(m0_bus.rvalid), 32'd1);
      if (c == 6) check("t3_busy_idle", 32'(busy), 32'd0);
      if (c == 7) check("t3_stray_per_rvalid", 32'(m0_bus.rvalid), 32'd0);
    end
    per_rvalid = 1'b0;

    // peripheral write from m1
    cyc();
    drive(1, 1'b1, 32'h1000_0004, 32'h55);
    @(negedge clk);
    check("t4_m1_gnt", 32'(m1_bus.gnt), 32'd1);
    check("t4_per_sel_we", {30'd0, per_sel, per_we}, 32'd3);
    check("t4_per_addr", per_addr, 32'h1000_0004);
    check("t4_per_wdata", per_wdata, 32'h55);
    check("t4_ram_en", 32'(ram_en), 32'd0);
    cyc();
    drop(1);
    @(negedge clk);
    check("t4_per_sel_off", 32'(per_sel), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // peripheral read that never answers
    cyc();
    drive(0, 1'b0, 32'h1000_0008, 32'h0);
`ifdef DBUS_TIMEOUT_EN
    q0.push_back(TMO_DATA);
`endif
    @(negedge clk);
    check("t5_per_sel", 32'(per_sel), 32'd1);
    hit = -1;
    for (int c = 1; c < 400 && hit < 0; c++) begin
      cyc();
      if (c == 1) drop(0);
      @(negedge clk);
      if (m0_bus.rvalid) hit = c;
    end
`ifdef DBUS_TIMEOUT_EN
    check("t5_tmo_cycle", 32'(hit), 32'd256);
    cyc();
    @(negedge clk);
    check("t5_tmo_cnt", 32'(tmo_cnt), 32'd1);
    cyc();
    drive(0, 1'b0, 32'h1000_0008, 32'h0);
    cyc();
    drop(0);
`else
    check("t5_still_waiting", 32'(hit), 32'hFFFF_FFFF);
`endif
    @(negedge clk);
    check("t6_busy_per_wait", 32'(busy), 32'd1);

    // reset while waiting on the peripheral
    cyc();
    drive(0, 1'b0, 32'h200, 32'h0);
    rstB = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_m0_gnt", 32'(m0_bus.gnt), 32'd0);
    check("t6_rst_m0_rdata", m0_bus.rdata, 32'd0);
    drop(0);
    repeat (2) @(negedge clk);
    rstB = 1'b1;
    repeat (3) cyc();

    // reset with two RAM reads in flight
    cyc();
    drive(0, 1'b0, 32'h40, 32'h0);
    q0.push_back(ram_word(32'h40));
    cyc();
    drop(0);
    drive(1, 1'b0, 32'h44, 32'h0);
    q1.push_back(ram_word(32'h44));
    cyc();
    drop(1);
    rstB = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("t6b_rst_m0_rvalid", 32'(m0_bus.rvalid), 32'd0);
    check("t6b_rst_busy", 32'(busy), 32'd0);
    check("t6b_rst_ram_en", 32'(ram_en), 32'd0);
    repeat (2) @(negedge clk);
    rstB = 1'b1;
    repeat (4) cyc();

    // normal access after reset
    drive(1, 1'b0, 32'h20, 32'h0);
    q1.push_back(ram_word(32'h20));
    @(negedge clk);
    check("t7_m1_gnt", 32'(m1_bus.gnt), 32'd1);
    check("t7_ram_addr", ram_addr, 32'h20);
    cyc();
    drop(1);
    cyc();
    @(negedge clk);
    check("t7_m1_rvalid", 32'(m1_bus.rvalid), 32'd1);
    repeat (2) cyc();

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
